// File: rtl/gain_ramp.sv
// gain_ramp: per-sample volume stage between the DDS sample source and the
// I2S transmitter. Each downstream request fetches one upstream sample,
// scales it by the current gain, then rounds and saturates the result. The
// gain moves toward gain_target by at most RAMP_STEP per completed sample.
module gain_ramp #(
   parameter int unsigned     DW        = 24,
   parameter int unsigned     GW        = 16,
   parameter logic [GW-1:0]   RAMP_STEP = 16'h0100,
   parameter logic [GW-1:0]   INIT_GAIN = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [GW-1:0]       gain_target,
   input  logic                rd_en,
   output logic                rd_valid,
   output logic [DW-1:0]       sample_out,
   output logic                up_ce,
   input  logic                up_valid,
   input  logic [DW-1:0]       up_sample,
   output logic [GW-1:0]       cur_gain,
   output logic                overrun
);

   localparam int unsigned PW = DW + GW + 1;

   // Rounding constant: one half LSB of the output after the GW-1 bit shift.
   localparam logic signed [PW-1:0] RND  = {{(PW-GW+1){1'b0}}, 1'b1, {(GW-2){1'b0}}};
   localparam logic signed [PW-1:0] SMAX = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [PW-1:0] SMIN = {{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      MUL,
      SAT
   } state_t;

   state_t               state_q, state_d;
   logic                 ce_q, ce_d;
   logic                 valid_q, valid_d;
   logic [DW-1:0]        out_q, out_d;
   logic [GW-1:0]        gain_q, gain_d;
   logic [DW-1:0]        samp_q, samp_d;
   logic signed [PW-1:0] prod_q, prod_d;
   logic                 ovr_q, ovr_d;

   logic signed [PW-1:0] samp_w;
   logic signed [PW-1:0] gain_w;
   logic signed [PW-1:0] rnd_sum;
   logic signed [PW-1:0] shr;
   logic [DW-1:0]        sat_val;
   logic [GW:0]          cur_w;
   logic [GW:0]          tgt_w;
   logic [GW:0]          up_w;
   logic [GW:0]          lim_w;
   logic [GW-1:0]        dn_w;
   logic [GW-1:0]        ramp_val;

   // Datapath: operand extension, round/shift/clamp, and the next ramped gain.
   always_comb begin
      samp_w  = {{(PW-DW){samp_q[DW-1]}}, samp_q};
      gain_w  = {{(PW-GW){1'b0}}, gain_q};
      rnd_sum = prod_q + RND;
      shr     = rnd_sum >>> (GW-1);
      if (shr > SMAX) begin
         sat_val = SMAX[DW-1:0];
      end else if (shr < SMIN) begin
         sat_val = SMIN[DW-1:0];
      end else begin
         sat_val = shr[DW-1:0];
      end

      // One extra bit lets the step overshoot past 0xFFFF or below 0 be
      // detected and clamped to the target instead of wrapping.
      cur_w = {1'b0, gain_q};
      tgt_w = {1'b0, gain_target};
      up_w  = cur_w + {1'b0, RAMP_STEP};
      lim_w = tgt_w + {1'b0, RAMP_STEP};
      dn_w  = gain_q - RAMP_STEP;
      if (cur_w < tgt_w) begin
         ramp_val = (up_w > tgt_w) ? gain_target : up_w[GW-1:0];
      end else if (cur_w > tgt_w) begin
         ramp_val = (cur_w < lim_w) ? gain_target : dn_w;
      end else begin
         ramp_val = gain_q;
      end
   end

   // Next-state and register updates for the request/fetch/scale sequence.
   always_comb begin
      state_d = state_q;
      ce_d    = 1'b0;
      valid_d = 1'b0;
      out_d   = out_q;
      gain_d  = gain_q;
      samp_d  = samp_q;
      prod_d  = prod_q;
      ovr_d   = ovr_q;

      if (rd_en && (state_q != IDLE)) begin
         ovr_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (rd_en) begin
               ce_d    = 1'b1;
               state_d = WAIT;
            end
         end
         WAIT: begin
            // A valid coincident with our own up_ce pulse is not accepted.
            if (up_valid && !ce_q) begin
               samp_d  = up_sample;
               state_d = MUL;
            end
         end
         MUL: begin
            prod_d  = samp_w * gain_w;
            state_d = SAT;
         end
         SAT: begin
            out_d   = sat_val;
            valid_d = 1'b1;
            gain_d  = ramp_val;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ce_q    <= 1'b0;
         valid_q <= 1'b0;
         out_q   <= '0;
         gain_q  <= INIT_GAIN;
         samp_q  <= '0;
         prod_q  <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ce_q    <= ce_d;
         valid_q <= valid_d;
         out_q   <= out_d;
         gain_q  <= gain_d;
         samp_q  <= samp_d;
         prod_q  <= prod_d;
         ovr_q   <= ovr_d;
      end
   end

   assign rd_valid   = valid_q;
   assign sample_out = out_q;
   assign up_ce      = ce_q;
   assign cur_gain   = gain_q;
   assign overrun    = ovr_q;

endmodule

// File: tb/tb_gain_ramp.sv
// tb_gain_ramp: directed and randomized transactions against an arithmetic
// reference model of the gain stage (scale, round, clamp, ramp).
module tb_gain_ramp;

   localparam int STEP = 'h1000;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] gain_target;
   logic        rd_en;
   logic        rd_valid;
   logic [23:0] sample_out;
   logic        up_ce;
   logic        up_valid;
   logic [23:0] up_sample;
   logic [15:0] cur_gain;
   logic        overrun;

   int n_checks = 0;
   int n_pass   = 0;
   int m_gain   = 0;
   bit m_ovr    = 0;
   int exp_ce   = 0;
   int exp_vld  = 0;
   int seen_ce  = 0;
   int seen_vld = 0;

   gain_ramp #(
      .DW(24),
      .GW(16),
      .RAMP_STEP(16'h1000),
      .INIT_GAIN(16'h0000)
   ) dut (
      .clk(clk),
      .rst(rst),
      .gain_target(gain_target),
      .rd_en(rd_en),
      .rd_valid(rd_valid),
      .sample_out(sample_out),
      .up_ce(up_ce),
      .up_valid(up_valid),
      .up_sample(up_sample),
      .cur_gain(cur_gain),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Count handshake pulses outside reset.
   always @(posedge clk) begin
      if (!rst) begin
         if (up_ce)    seen_ce  = seen_ce + 1;
         if (rd_valid) seen_vld = seen_vld + 1;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (got === exp) n_pass = n_pass + 1;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Reference: round-half-up of s*g/2^15, clamped to 24-bit signed range.
   function automatic logic [23:0] model_out(input logic [23:0] s, input int g);
      longint p;
      p = longint'($signed(s)) * longint'(g);
      p = (p + 64'sd16384) >>> 15;
      if (p > 64'sd8388607)  p = 64'sd8388607;
      if (p < -64'sd8388608) p = -64'sd8388608;
      return p[23:0];
   endfunction

   function automatic int model_ramp(input int g, input int t);
      if (g < t) return (g + STEP > t) ? t : g + STEP;
      if (g > t) return (g - STEP < t) ? t : g - STEP;
      return g;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One read transaction. early: up_valid raised in the up_ce cycle with a
   // decoy sample; extra: rd_en while waiting; sat_rd: rd_en in the SAT cycle.
   task automatic txn(input logic [23:0] s, input int delay, input bit early,
                      input bit extra, input bit sat_rd, input bit spur);
      logic [23:0] exp_s;
      int lat;
      tick();
      if (spur) begin
         up_valid = 1'b1; up_sample = $urandom;
         tick();
         up_valid = 1'b0;
      end
      rd_en = 1'b1;
      exp_ce = exp_ce + 1;
      tick();
      rd_en = 1'b0;
      if (early) begin
         up_valid = 1'b1; up_sample = ~s;
      end
      @(negedge clk);
      check("up_ce_pulse", up_ce, 1);
      tick();
      if (!early) begin
         repeat (delay) tick();
      end
      up_valid = 1'b1; up_sample = s;
      if (extra) begin
         rd_en = 1'b1; m_ovr = 1'b1;
      end
      @(negedge clk);
      check("up_ce_width", up_ce, 0);
      tick();
      up_valid = 1'b0; rd_en = 1'b0; up_sample = $urandom;
      lat = 1;
      while (lat < 8) begin
         @(negedge clk);
         if (rd_valid) break;
         tick();
         rd_en = (lat == 1) && sat_rd;
         if (rd_en) m_ovr = 1'b1;
         lat = lat + 1;
      end
      rd_en = 1'b0;
      exp_s  = model_out(s, m_gain);
      m_gain = model_ramp(m_gain, int'(gain_target));
      exp_vld = exp_vld + 1;
      check("latency", lat, 3);
      check("sample_out", sample_out, exp_s);
      check("cur_gain", cur_gain, m_gain);
      check("overrun", overrun, m_ovr);
      tick();
      @(negedge clk);
      check("rd_valid_width", rd_valid, 0);
      check("sample_hold", sample_out, exp_s);
   endtask

   task automatic reset_in_wait();
      tick();
      rd_en = 1'b1;
      exp_ce = exp_ce + 1;
      tick();
      rd_en = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_gain = 0; m_ovr = 1'b0;
      @(negedge clk);
      check("rst_cur_gain", cur_gain, 0);
      check("rst_overrun", overrun, 0);
      check("rst_sample_out", sample_out, 0);
      check("rst_up_ce", up_ce, 0);
      tick();
      up_valid = 1'b1; up_sample = $urandom;
      tick();
      up_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rst_no_valid", rd_valid, 0);
         tick();
      end
   endtask

   function automatic logic [23:0] rand_sample();
      logic [23:0] r;
      case ($urandom_range(0, 5))
         0: r = 24'h7FFFFF;
         1: r = 24'h800000;
         2: r = 24'hFFFFFF;
         default: r = $urandom;
      endcase
      return r;
   endfunction

   initial begin
      rst = 1'b1; rd_en = 1'b0; up_valid = 1'b0; up_sample = '0; gain_target = '0;
      repeat (3) tick();
      @(negedge clk);
      check("reset_rd_valid", rd_valid, 0);
      check("reset_sample_out", sample_out, 0);
      check("reset_up_ce", up_ce, 0);
      check("reset_cur_gain", cur_gain, 0);
      check("reset_overrun", overrun, 0);
      tick();
      rst = 1'b0;

      // Fade in from mute toward unity.
      gain_target = 16'h8000;
      repeat (10) txn(24'h400000, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("ramp_final_out", sample_out, 24'h400000);
      check("ramp_final_gain", cur_gain, 16'h8000);

      // Ramp to max gain, then saturate both ways.
      gain_target = 16'hFFFF;
      repeat (8) txn(24'h001234, 1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("max_gain", cur_gain, 16'hFFFF);
      txn(24'h7FFFFF, 2, 1'b0, 1'b0, 1'b0, 1'b0);
      check("sat_pos", sample_out, 24'h7FFFFF);
      txn(24'h800000, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("sat_neg", sample_out, 24'h800000);

      // Back to unity; -1 must stay -1.
      gain_target = 16'h8000;
      repeat (8) txn(rand_sample(), 0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("unity_gain", cur_gain, 16'h8000);
      txn(24'hFFFFFF, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("minus_one", sample_out, 24'hFFFFFF);

      // Downward ramp clamping at a small target, then retarget below one step.
      gain_target = 16'h0150;
      repeat (9) txn(rand_sample(), 0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("gain_0150", cur_gain, 16'h0150);
      gain_target = 16'h0050;
      txn(rand_sample(), 0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("gain_0050", cur_gain, 16'h0050);
      txn(rand_sample(), 0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("gain_0050_hold", cur_gain, 16'h0050);

      // Overrun is sticky until reset.
      txn(rand_sample(), 2, 1'b0, 1'b1, 1'b0, 1'b0);
      check("overrun_set", overrun, 1);
      txn(rand_sample(), 1, 1'b0, 1'b0, 1'b0, 1'b1);
      check("overrun_hold", overrun, 1);
      reset_in_wait();
      txn(24'h400000, 0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Randomized traffic.
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 2) == 0) begin
            case ($urandom_range(0, 3))
               0: gain_target = 16'hFFFF;
               1: gain_target = 16'h0000;
               default: gain_target = $urandom;
            endcase
         end
         if ($urandom_range(0, 39) == 0) reset_in_wait();
         txn(rand_sample(), $urandom_range(0, 4), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 4) == 0));
      end

      tick();
      repeat (3) tick();
      check("up_ce_count", seen_ce, exp_ce);
      check("rd_valid_count", seen_vld, exp_vld);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
